simon_seq_player: RTL

- Playback side of the Simon game. The game state machine builds a packed colour sequence; this block presents it to the player.
- Each entry lights one colour LED for a fixed number of scan ticks, followed by a dark gap. After the last entry it signals completion, so the game can move on to user input.
- Sits between the game state machine and the LED, SSD and VGA colour drivers.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_color_decode.sv | 22 ++
 rtl/simon_seq_player.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour codes, sequence geometry and one-hot state encoding.
// Used by the game state machine, the sequence player and the colour drivers.
package simon_pkg;

  localparam int SIMON_CW      = 3;
  localparam int SIMON_MAX_LEN = 10;

  localparam logic [SIMON_CW-1:0] COL_NONE   = 3'd0;
  localparam logic [SIMON_CW-1:0] COL_RED    = 3'd1;
  localparam logic [SIMON_CW-1:0] COL_BLUE   = 3'd2;
  localparam logic [SIMON_CW-1:0] COL_YELLOW = 3'd3;
  localparam logic [SIMON_CW-1:0] COL_GREEN  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SHOW = 4'b0010,
    ST_GAP  = 4'b0100,
    ST_DONE = 4'b1000
  } simon_state_e;

endpackage

// File: rtl/simon_color_decode.sv
// Combinational colour code to one-hot LED decoder; unknown codes stay dark.
// Shared with the VGA colour path.
module simon_color_decode
  import simon_pkg::*;
#(
  parameter int CW = SIMON_CW
) (
  input  logic [CW-1:0] code,
  output logic [3:0]    led
);

  always_comb begin
    case (code)
      CW'(COL_RED):    led = 4'b0001;
      CW'(COL_BLUE):   led = 4'b0010;
      CW'(COL_YELLOW): led = 4'b0100;
      CW'(COL_GREEN):  led = 4'b1000;
      default:         led = 4'b0000;
    endcase
  end

endmodule

// File: rtl/simon_seq_player.sv
// Simon playback: lights each latched sequence entry for ON_TICKS ticks, then a GAP_TICKS dark gap.
// Optional tone output when SIMON_TONE_EN is defined.
module simon_seq_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN   = SIMON_MAX_LEN,
  parameter int CW        = SIMON_CW,
  parameter int ON_TICKS  = 4,
  parameter int GAP_TICKS = 2,
  parameter int TONE_DIV  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_en,
  input  logic                  start,
  input  logic                  abort,
  input  logic [MAX_LEN*CW-1:0] seq,
  input  logic [3:0]            len,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            idx,
  output logic [CW-1:0]         color_code,
  output logic [3:0]            led
`ifdef SIMON_TONE_EN
  ,
  output logic                  tone
`endif
);

  localparam int CNT_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  simon_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            len_q, len_d;
  logic [MAX_LEN*CW-1:0] seq_q, seq_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         code_q, code_d;
  logic [3:0]            led_q, led_d;
  logic [CW-1:0]         entry_code;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    seq_d   = seq_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (len == 4'd0) begin
            done_d = 1'b1;
          end else begin
            seq_d   = seq;
            len_d   = (len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len;
            idx_d   = 4'd0;
            cnt_d   = CNT_W'(ON_TICKS);
            state_d = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (tick_en) begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = CNT_W'(GAP_TICKS);
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick_en) begin
          if (cnt_q == CNT_W'(1)) begin
            if (idx_q == len_q - 4'd1) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              cnt_d   = CNT_W'(ON_TICKS);
              state_d = ST_SHOW;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything outside IDLE, including a completion in the same cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    entry_code = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx_d == 4'(k)) entry_code = seq_d[k*CW +: CW];
    end
  end

  // Outputs are registered from the next-state view so they line up with the state change.
  always_comb begin
    busy_d = (state_d == ST_SHOW) || (state_d == ST_GAP);
    code_d = (state_d == ST_SHOW) ? entry_code : '0;
  end

  simon_color_decode #(.CW(CW)) u_decode (
    .code (code_d),
    .led  (led_d)
  );

`ifdef SIMON_TONE_EN
  localparam int TONE_W = $clog2(TONE_DIV * (2**CW) + 1);

  logic              tone_q, tone_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [TONE_W-1:0] half_period;

  always_comb begin
    half_period = TONE_W'(TONE_DIV) * TONE_W'(code_q);
    tone_d      = 1'b0;
    tone_cnt_d  = '0;
    // Divider restarts on every SHOW entry; only valid colours (non-zero led) sound.
    if (state_d == ST_SHOW && state_q == ST_SHOW && led_q != 4'd0) begin
      if (tone_cnt_q == half_period - TONE_W'(1)) begin
        tone_d = ~tone_q;
      end else begin
        tone_d     = tone_q;
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
      end
    end
  end

  assign tone = tone_q;
`endif

  // NOTE: all state updates live in one clocked block using non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      len_q      <= 4'd0;
      seq_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      code_q     <= '0;
      led_q      <= 4'd0;
`ifdef SIMON_TONE_EN
      tone_q     <= 1'b0;
      tone_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      code_q     <= code_d;
      led_q      <= led_d;
`ifdef SIMON_TONE_EN
      tone_q     <= tone_d;
      tone_cnt_q <= tone_cnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign idx        = idx_q;
  assign color_code = code_q;
  assign led        = led_q;

endmodule
